// File: rtl/nlms_sample_driver.sv
// nlms_sample_driver: buffers (x, d) sample pairs from an upstream stream in a
// small FIFO and issues them to the NLMS core one pair per start pulse,
// counting issued pairs against a programmed run length.
module nlms_sample_driver #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go,
    input  logic [CNT_WIDTH-1:0]        num_samples,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_x,
    input  logic [DATA_WIDTH-1:0]       s_d,
    output logic                        core_start,
    input  logic                        core_ready,
    input  logic                        core_idle,
    output logic [DATA_WIDTH-1:0]       input_signal,
    output logic [DATA_WIDTH-1:0]       desired_signal_out,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_WIDTH-1:0]        sample_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [PW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_s_ready;

    logic [CNT_WIDTH-1:0]  r_n;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_core_start;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_d;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_cnt_inc;
    logic                  w_set_done;
    logic [LW-1:0]         w_level_nxt;
    logic [CNT_WIDTH-1:0]  w_count_inc;
    logic [PW-1:0]         w_head;

    // s_ready is registered, so a full FIFO refuses a push even when it pops
    // in the same cycle; no entry is ever overwritten.
    assign w_push      = s_valid && r_s_ready;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    assign w_count_inc = r_count + CNT_WIDTH'(1);
    assign w_head      = r_mem[r_rd_ptr];

    // FIFO storage; contents need no reset because the pointers qualify them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_x, s_d};
        end
    end

    // FIFO pointers, occupancy and upstream ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_s_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level   <= w_level_nxt;
            r_s_ready <= (w_level_nxt != LW'(FIFO_DEPTH));
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-cycle action strobes
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_cnt_inc   = 1'b0;
        w_set_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_load      = 1'b1;
                    w_state_nxt = (num_samples != '0) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                if ((r_level != '0) && core_ready && (r_count < r_n)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_inc   = 1'b1;
                w_state_nxt = (w_count_inc == r_n) ? S_DRAIN : S_RUN;
            end
            S_DRAIN: begin
                if (core_idle && !r_core_start) begin
                    w_set_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run bookkeeping, start pulse and the issued pair held toward the core
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n          <= '0;
            r_count      <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_core_start <= 1'b0;
            r_x          <= '0;
            r_d          <= '0;
        end else begin
            if (w_load) begin
                r_n     <= num_samples;
                r_count <= '0;
                r_done  <= 1'b0;
            end
            if (w_cnt_inc) begin
                r_count <= w_count_inc;
            end
            if (w_set_done) begin
                r_done <= 1'b1;
            end
            r_busy       <= (w_state_nxt != S_IDLE);
            r_core_start <= w_pop;
            if (w_pop) begin
                {r_x, r_d} <= w_head;
            end
        end
    end

    assign s_ready            = r_s_ready;
    assign core_start         = r_core_start;
    assign input_signal       = r_x;
    assign desired_signal_out = r_d;
    assign busy               = r_busy;
    assign done               = r_done;
    assign sample_count       = r_count;
    assign fifo_level         = r_level;

endmodule

// File: tb/tb_nlms_sample_driver.sv
// Testbench for nlms_sample_driver: directed scenarios plus randomized runs
// checked against a queue-based model of the sample stream.
module tb_nlms_sample_driver;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [CW-1:0] num_samples;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_x;
    logic [DW-1:0] s_d;
    logic          core_start;
    logic          core_ready;
    logic          core_idle;
    logic [DW-1:0] input_signal;
    logic [DW-1:0] desired_signal_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] sample_count;
    logic [3:0]    fifo_level;

    nlms_sample_driver #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .go                (go),
        .num_samples       (num_samples),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_x               (s_x),
        .s_d               (s_d),
        .core_start        (core_start),
        .core_ready        (core_ready),
        .core_idle         (core_idle),
        .input_signal      (input_signal),
        .desired_signal_out(desired_signal_out),
        .busy              (busy),
        .done              (done),
        .sample_count      (sample_count),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] mq[$];       // accepted pairs {x,d} not yet issued
    bit          st_seen;
    bit          st_empty;
    logic [31:0] st_exp;
    bit          smp_rdy;
    bit          smp_idle;
    bit          smp_push;
    int          lvl_prev;

    // Advance one clock; track accepted pushes and the pair each start must carry.
    task automatic step();
        logic [31:0] pr;
        bit acc;
        acc      = (s_valid === 1'b1) && (mq.size() < DEPTH);
        pr       = {s_x, s_d};
        smp_rdy  = (core_ready === 1'b1);
        smp_idle = (core_idle === 1'b1);
        smp_push = acc;
        lvl_prev = mq.size();
        @(posedge clk);
        #1;
        cyc++;
        if (acc) mq.push_back(pr);
        st_seen  = (core_start === 1'b1);
        st_empty = 1'b0;
        st_exp   = '0;
        if (st_seen) begin
            if (mq.size() == 0) st_empty = 1'b1;
            else st_exp = mq.pop_front();
        end
    endtask

    task automatic push_pairs(input int n, input int x0, input int d0);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_x     = 16'(x0 + i);
            s_d     = 16'(d0 + i);
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; num_samples = '0; s_valid = 1'b0;
        s_x = '0; s_d = '0; core_ready = 1'b0; core_idle = 1'b0;
        #3 rst = 1'b0;
        #4;
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL rst_core_start got=%0b exp=0", core_start); end
        total++; if (input_signal !== 16'd0) begin bad++; $display("FAIL rst_input_signal got=%0h exp=0", input_signal); end
        total++; if (desired_signal_out !== 16'd0) begin bad++; $display("FAIL rst_desired got=%0h exp=0", desired_signal_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
        total++; if (sample_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", sample_count); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%0b exp=1", s_ready); end
        @(posedge clk);
        #1 rst = 1'b1;
        mq.delete();
    endtask

    task automatic test_basic_run();
        bit exp_st;
        core_ready = 1'b1; core_idle = 1'b1;
        push_pairs(4, 1, 101);
        total++; if (fifo_level !== 4'd4) begin bad++; $display("FAIL basic_prefill got=%0d exp=4", fifo_level); end
        go = 1'b1; num_samples = 16'd4;
        step();
        go = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        for (int k = 2; k <= 10; k++) begin
            step();
            exp_st = (k % 2 == 0) && (k <= 8);
            total++;
            if (core_start !== exp_st) begin bad++; $display("FAIL basic_start k=%0d got=%0b exp=%0b", k, core_start, exp_st); end
            if (exp_st) begin
                total++;
                if ({input_signal, desired_signal_out} !== {16'(k / 2), 16'(100 + k / 2)})
                    begin bad++; $display("FAIL basic_data k=%0d got=%0d/%0d exp=%0d/%0d", k, input_signal, desired_signal_out, k / 2, 100 + k / 2); end
            end
            if (k == 9) begin
                total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_early_done got=%0b%0b exp=01", done, busy); end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0b exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%0b exp=0", busy); end
        total++; if (sample_count !== 16'd4) begin bad++; $display("FAIL basic_count got=%0d exp=4", sample_count); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL basic_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_backpressure();
        int n;
        bit fin;
        core_ready = 1'b1; core_idle = 1'b1;
        push_pairs(4, 11, 211);
        go = 1'b1; num_samples = 16'd4;
        step();
        go = 1'b0;
        step();
        total++; if (core_start !== 1'b1 || input_signal !== 16'd11) begin bad++; $display("FAIL bp_first got=%0b/%0d exp=1/11", core_start, input_signal); end
        core_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (core_start !== 1'b0) begin bad++; $display("FAIL bp_stalled i=%0d got=%0b exp=0", i, core_start); end
        end
        core_ready = 1'b1;
        step();
        total++;
        if (core_start !== 1'b1 || input_signal !== 16'd12 || desired_signal_out !== 16'd212)
            begin bad++; $display("FAIL bp_resume got=%0b/%0d/%0d exp=1/12/212", core_start, input_signal, desired_signal_out); end
        n = 2; fin = 1'b0;
        for (int i = 0; i < 30 && !fin; i++) begin
            step();
            if (st_seen) begin
                n++;
                total++;
                if (st_empty || {input_signal, desired_signal_out} !== st_exp)
                    begin bad++; $display("FAIL bp_data got=%0h exp=%0h", {input_signal, desired_signal_out}, st_exp); end
            end
            if (done === 1'b1) fin = 1'b1;
        end
        total++; if (!fin) begin bad++; $display("FAIL bp_timeout got=0 exp=1"); end
        total++; if (n != 4) begin bad++; $display("FAIL bp_starts got=%0d exp=4", n); end
        total++; if (sample_count !== 16'd4 || fifo_level !== 4'd0) begin bad++; $display("FAIL bp_end got=%0d/%0d exp=4/0", sample_count, fifo_level); end
    endtask

    task automatic test_fifo_full();
        int  n;
        int  since;
        int  simul;
        bit  fin;
        core_ready = 1'b1; core_idle = 1'b1;
        push_pairs(DEPTH, 300, 400);
        total++; if (fifo_level !== 4'd8 || s_ready !== 1'b0) begin bad++; $display("FAIL full_level got=%0d/%0b exp=8/0", fifo_level, s_ready); end
        s_valid = 1'b1; s_x = 16'hdead; s_d = 16'hbeef;
        step();
        s_valid = 1'b0;
        total++; if (fifo_level !== 4'd8 || s_ready !== 1'b0) begin bad++; $display("FAIL full_no_overwrite got=%0d/%0b exp=8/0", fifo_level, s_ready); end
        go = 1'b1; num_samples = 16'd8;
        step();
        go = 1'b0;
        n = 0; since = 9; simul = 0; fin = 1'b0;
        for (int i = 0; i < 60 && !fin; i++) begin
            s_valid = (n >= 2) && (since == 1);
            s_x = 16'($urandom); s_d = 16'($urandom);
            step();
            total++; if (fifo_level !== 4'(mq.size())) begin bad++; $display("FAIL full_level_track got=%0d exp=%0d", fifo_level, mq.size()); end
            if (st_seen) begin
                n++; since = 0;
                total++;
                if (st_empty || {input_signal, desired_signal_out} !== st_exp)
                    begin bad++; $display("FAIL full_data got=%0h exp=%0h", {input_signal, desired_signal_out}, st_exp); end
                if (smp_push) begin
                    simul++;
                    total++; if (fifo_level !== 4'(lvl_prev)) begin bad++; $display("FAIL full_pushpop got=%0d exp=%0d", fifo_level, lvl_prev); end
                end
            end else begin
                since++;
            end
            if (done === 1'b1) fin = 1'b1;
        end
        s_valid = 1'b0;
        total++; if (!fin) begin bad++; $display("FAIL full_timeout got=0 exp=1"); end
        total++; if (simul != 6) begin bad++; $display("FAIL full_simul_count got=%0d exp=6", simul); end
        total++; if (sample_count !== 16'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", sample_count); end
    endtask

    task automatic test_zero_and_go_busy();
        int n;
        bit fin;
        core_ready = 1'b1; core_idle = 1'b1;
        go = 1'b1; num_samples = 16'd0;
        step();
        go = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0 || core_start !== 1'b0) begin bad++; $display("FAIL zero_t1 got=%0b%0b%0b exp=100", busy, done, core_start); end
        step();
        total++; if (done !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0) begin bad++; $display("FAIL zero_done got=%0b%0b%0b exp=100", done, busy, core_start); end
        total++; if (sample_count !== 16'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", sample_count); end
        n = 0; fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            go = (i == 0) || (i == 3);
            num_samples = (i == 0) ? 16'd5 : 16'd2;
            step();
            if (st_seen) begin
                n++;
                total++;
                if (st_empty || {input_signal, desired_signal_out} !== st_exp)
                    begin bad++; $display("FAIL gobusy_data got=%0h exp=%0h", {input_signal, desired_signal_out}, st_exp); end
            end
            if (i > 0 && done === 1'b1) fin = 1'b1;
        end
        go = 1'b0;
        total++; if (!fin) begin bad++; $display("FAIL gobusy_timeout got=0 exp=1"); end
        total++; if (n != 5) begin bad++; $display("FAIL gobusy_starts got=%0d exp=5", n); end
        total++; if (sample_count !== 16'd5) begin bad++; $display("FAIL gobusy_count got=%0d exp=5", sample_count); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit fin;
        core_ready = 1'b1; core_idle = 1'b1;
        push_pairs(DEPTH - mq.size(), 500, 600);
        go = 1'b1; num_samples = 16'd10;
        step();
        go = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && n < 3; i++) begin
            step();
            if (st_seen) n++;
        end
        total++; if (n != 3) begin bad++; $display("FAIL rmid_pre_starts got=%0d exp=3", n); end
        #2 rst = 1'b0;
        #1;
        total++; if ({core_start, busy, done, s_ready} !== 4'b0001) begin bad++; $display("FAIL rmid_ctrl got=%4b exp=0001", {core_start, busy, done, s_ready}); end
        total++; if (input_signal !== 16'd0 || desired_signal_out !== 16'd0) begin bad++; $display("FAIL rmid_data got=%0h/%0h exp=0/0", input_signal, desired_signal_out); end
        total++; if (sample_count !== 16'd0 || fifo_level !== 4'd0) begin bad++; $display("FAIL rmid_count_level got=%0d/%0d exp=0/0", sample_count, fifo_level); end
        mq.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        push_pairs(2, 700, 800);
        go = 1'b1; num_samples = 16'd2;
        step();
        go = 1'b0;
        n = 0; fin = 1'b0;
        for (int i = 0; i < 30 && !fin; i++) begin
            step();
            if (st_seen) begin
                n++;
                total++;
                if (st_empty || {input_signal, desired_signal_out} !== st_exp)
                    begin bad++; $display("FAIL rmid_post_data got=%0h exp=%0h", {input_signal, desired_signal_out}, st_exp); end
            end
            if (done === 1'b1) fin = 1'b1;
        end
        total++; if (!fin || n != 2) begin bad++; $display("FAIL rmid_post_run got=%0d/%0b exp=2/1", n, fin); end
        total++; if (sample_count !== 16'd2 || fifo_level !== 4'd0) begin bad++; $display("FAIL rmid_post_end got=%0d/%0d exp=2/0", sample_count, fifo_level); end
    endtask

    task automatic test_random();
        int   nreq;
        int   n;
        int   last;
        int   drain_edge;
        bit   fin;
        logic exp_done;
        for (int r = 0; r < 4; r++) begin
            nreq = $urandom_range(1, 12);
            push_pairs($urandom_range(0, 3), $urandom_range(0, 60000), $urandom_range(0, 60000));
            core_ready = 1'b1; core_idle = 1'b1;
            go = 1'b1; num_samples = 16'(nreq);
            step();
            go = 1'b0;
            total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rnd_go run=%0d got=%0b%0b exp=10", r, busy, done); end
            n = 0; last = -10; drain_edge = 1 << 30; fin = 1'b0;
            for (int i = 0; i < 400 && !fin; i++) begin
                s_valid    = 1'($urandom_range(0, 1));
                s_x        = 16'($urandom);
                s_d        = 16'($urandom);
                core_ready = ($urandom_range(0, 9) < 7);
                core_idle  = ($urandom_range(0, 9) < 5);
                step();
                total++; if (fifo_level !== 4'(mq.size())) begin bad++; $display("FAIL rnd_level got=%0d exp=%0d", fifo_level, mq.size()); end
                total++; if (s_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_s_ready got=%0b exp=%0b", s_ready, mq.size() < DEPTH); end
                if (st_seen) begin
                    n++;
                    total++;
                    if (st_empty || {input_signal, desired_signal_out} !== st_exp)
                        begin bad++; $display("FAIL rnd_data got=%0h exp=%0h", {input_signal, desired_signal_out}, st_exp); end
                    total++; if (!smp_rdy) begin bad++; $display("FAIL rnd_start_no_ready got=1 exp=0"); end
                    total++; if (cyc - last < 2 || n > nreq) begin bad++; $display("FAIL rnd_start_rate gap=%0d n=%0d exp_n_max=%0d", cyc - last, n, nreq); end
                    last = cyc;
                    if (n == nreq) drain_edge = cyc + 2;
                end
                exp_done = (n == nreq) && (cyc >= drain_edge) && smp_idle;
                total++; if (done !== exp_done) begin bad++; $display("FAIL rnd_done cyc=%0d got=%0b exp=%0b", cyc, done, exp_done); end
                if (exp_done || done === 1'b1) fin = 1'b1;
            end
            s_valid = 1'b0;
            total++; if (!fin) begin bad++; $display("FAIL rnd_timeout run=%0d got=0 exp=1", r); end
            total++; if (n != nreq || sample_count !== 16'(nreq)) begin bad++; $display("FAIL rnd_count got=%0d/%0d exp=%0d", n, sample_count, nreq); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy_end got=%0b exp=0", busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_backpressure();
        test_fifo_full();
        test_zero_and_go_busy();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
